// File: rtl/cursor_pkg.sv
// Shared constants, state encoding and PS/2 header bit positions for the
// cursor position tracker.
package cursor_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

    localparam int SYNC = 3;
    localparam int XS   = 4;
    localparam int YS   = 5;
    localparam int XO   = 6;
    localparam int YO   = 7;

endpackage

// File: rtl/cursor_axis_accum.sv
// One axis of the cursor: adds (or subtracts) a scaled 9-bit signed mouse
// delta to the current position and clamps the result to 0..MAX.
module cursor_axis_accum #(
    parameter int MAX   = 639,
    parameter int SHIFT = 0
) (
    input  logic [10:0] pos,
    input  logic [8:0]  delta,
    input  logic        negate,
    output logic [10:0] next
);

    localparam logic signed [12:0] MAX_S = 13'(MAX);

    logic signed [12:0] d_ext;
    logic signed [12:0] d_sh;
    logic signed [12:0] pos_s;
    logic signed [12:0] sum;

    always_comb begin
        d_ext = {{4{delta[8]}}, delta};
        d_sh  = d_ext <<< SHIFT;
        pos_s = {2'b00, pos};
        sum   = negate ? (pos_s - d_sh) : (pos_s + d_sh);
        if (sum[12])
            next = '0;
        else if (sum > MAX_S)
            next = MAX_S[10:0];
        else
            next = sum[10:0];
    end

endmodule

// File: rtl/cursor_position_tracker.sv
// Assembles 3-byte PS/2 mouse packets into an absolute, clamped cursor
// position and button state, with an inter-byte timeout.
//
// state   | meaning
// WAIT_B0 | idle, next byte with sync bit set starts a packet
// WAIT_B1 | header latched, waiting for X delta byte
// WAIT_B2 | X delta latched, waiting for Y delta byte
// APPLY   | packet complete, outputs update this cycle
module cursor_position_tracker
    import cursor_pkg::*;
#(
    parameter int SCREEN_W       = cursor_pkg::SCREEN_W,
    parameter int SCREEN_H       = cursor_pkg::SCREEN_H,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SPEED_SHIFT    = 0
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [10:0] cursor_x,
    output logic [10:0] cursor_y,
    output logic [2:0]  buttons,
    output logic        pos_update,
    output logic        sync_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timeout_cnt;
    logic [2:0]    hdr_btn;
    logic          hdr_xs, hdr_ys, hdr_xo, hdr_yo;
    logic [7:0]    b1, b2;
    logic [8:0]    dx, dy;
    logic [10:0]   nx, ny;

    // Overflowed axes contribute no motion; buttons are still taken.
    assign dx = hdr_xo ? 9'd0 : {hdr_xs, b1};
    assign dy = hdr_yo ? 9'd0 : {hdr_ys, b2};

    cursor_axis_accum #(.MAX(SCREEN_W - 1), .SHIFT(SPEED_SHIFT)) u_accum_x (
        .pos    (cursor_x),
        .delta  (dx),
        .negate (1'b0),
        .next   (nx)
    );

    cursor_axis_accum #(.MAX(SCREEN_H - 1), .SHIFT(SPEED_SHIFT)) u_accum_y (
        .pos    (cursor_y),
        .delta  (dy),
        .negate (1'b1),
        .next   (ny)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state       <= WAIT_B0;
            timeout_cnt <= '0;
            cursor_x    <= 11'(INIT_X);
            cursor_y    <= 11'(INIT_Y);
            buttons     <= '0;
            pos_update  <= 1'b0;
            sync_error  <= 1'b0;
            hdr_btn     <= '0;
            hdr_xs      <= 1'b0;
            hdr_ys      <= 1'b0;
            hdr_xo      <= 1'b0;
            hdr_yo      <= 1'b0;
            b1          <= '0;
            b2          <= '0;
        end else begin
            pos_update <= 1'b0;
            sync_error <= 1'b0;
            case (state)
                WAIT_B0, APPLY: begin
                    if (state == APPLY) begin
                        cursor_x   <= nx;
                        cursor_y   <= ny;
                        buttons    <= hdr_btn;
                        pos_update <= 1'b1;
                    end
                    timeout_cnt <= '0;
                    state       <= WAIT_B0;
                    // A byte arriving during APPLY is already a packet-start candidate.
                    if (byte_valid) begin
                        if (byte_data[SYNC]) begin
                            hdr_btn <= byte_data[2:0];
                            hdr_xs  <= byte_data[XS];
                            hdr_ys  <= byte_data[YS];
                            hdr_xo  <= byte_data[XO];
                            hdr_yo  <= byte_data[YO];
                            state   <= WAIT_B1;
                        end else begin
                            sync_error <= 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (byte_valid) begin
                        timeout_cnt <= '0;
                        if (state == WAIT_B1) begin
                            b1    <= byte_data;
                            state <= WAIT_B2;
                        end else begin
                            b2    <= byte_data;
                            state <= APPLY;
                        end
                    end else if (timeout_cnt == TC_LAST) begin
                        timeout_cnt <= '0;
                        state       <= WAIT_B0;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_position_tracker.sv
// Directed bench for cursor_position_tracker: a packet-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_cursor_position_tracker;

    localparam int T       = 64;
    localparam int SHIFT   = 0;
    localparam int W       = 640;
    localparam int H       = 480;
    localparam int INIT_X  = 320;
    localparam int INIT_Y  = 240;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [10:0] cursor_x, cursor_y;
    logic [2:0]  buttons;
    logic        pos_update, sync_error;

    int total = 0;
    int bad = 0;
    int pu_cnt = 0;
    int se_cnt = 0;

    cursor_position_tracker #(
        .SCREEN_W(W), .SCREEN_H(H), .INIT_X(INIT_X), .INIT_Y(INIT_Y),
        .TIMEOUT_CYCLES(T), .SPEED_SHIFT(SHIFT)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .buttons    (buttons),
        .pos_update (pos_update),
        .sync_error (sync_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes collected into a packet queue; a packet with a
    // gap longer than T cycles between bytes is dropped.
    int          mx, my;
    logic [2:0]  mb;
    bit          mpu, mse, mvalid = 0, pend;
    logic [7:0]  q[$];
    logic [7:0]  p0, p1, p2;
    int          idle_cnt;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta9(input logic sgn, input logic [7:0] mag);
        return sgn ? int'(mag) - 256 : int'(mag);
    endfunction

    always @(posedge CLOCK_50) begin
        if (!reset) begin
            mx = INIT_X; my = INIT_Y; mb = 3'b000; mpu = 0; mse = 0;
            q.delete(); idle_cnt = 0; pend = 0; mvalid = 1;
        end else if (mvalid) begin
            mpu = 0; mse = 0;
            if (pend) begin
                int dxm, dym;
                dxm = p0[6] ? 0 : delta9(p0[4], p1) * (1 << SHIFT);
                dym = p0[7] ? 0 : delta9(p0[5], p2) * (1 << SHIFT);
                mx = clampi(mx + dxm, W - 1);
                my = clampi(my - dym, H - 1);
                mb = p0[2:0];
                mpu = 1;
                pend = 0;
            end
            if (q.size() == 0) begin
                if (byte_valid) begin
                    if (byte_data[3]) begin q.push_back(byte_data); idle_cnt = 0; end
                    else mse = 1;
                end
            end else if (byte_valid) begin
                q.push_back(byte_data);
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt == T) begin q.delete(); idle_cnt = 0; end
            end
            if (q.size() == 3) begin
                p0 = q[0]; p1 = q[1]; p2 = q[2];
                q.delete();
                pend = 1;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (mvalid) begin
            chk("cyc_x", 32'(cursor_x), 32'(mx));
            chk("cyc_y", 32'(cursor_y), 32'(my));
            chk("cyc_buttons", 32'(buttons), 32'(mb));
            chk("cyc_pos_update", 32'(pos_update), 32'(mpu));
            chk("cyc_sync_error", 32'(sync_error), 32'(mse));
            if (pos_update === 1'b1) pu_cnt++;
            if (sync_error === 1'b1) se_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLOCK_50); #1; end
    endtask

    task automatic strobe(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        strobe(a); strobe(b); strobe(c);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    int pu0, se0;

    initial begin
        @(posedge CLOCK_50); #1;
        do_reset();
        chk("reset_x", 32'(cursor_x), 320);
        chk("reset_y", 32'(cursor_y), 240);
        chk("reset_buttons", 32'(buttons), 0);

        // basic packet
        pu0 = pu_cnt;
        pkt(8'h08, 8'h05, 8'h03); idle(3);
        chk("t1_x", 32'(cursor_x), 325);
        chk("t1_y", 32'(cursor_y), 237);
        chk("t1_buttons", 32'(buttons), 0);
        chk("t1_pu_count", 32'(pu_cnt - pu0), 1);

        // negative delta with left button, then saturate at 0
        do_reset();
        pkt(8'h19, 8'hF6, 8'h00); idle(3);
        chk("t2_x", 32'(cursor_x), 310);
        chk("t2_buttons", 32'(buttons), 1);
        for (int i = 0; i < 40; i++) begin pkt(8'h19, 8'hF6, 8'h00); idle(1); end
        idle(2);
        chk("t2_sat_x", 32'(cursor_x), 0);

        // clamp to right edge and top, then bottom
        do_reset();
        for (int i = 0; i < 3; i++) begin pkt(8'h08, 8'h7F, 8'h7F); idle(1); end
        idle(2);
        chk("clamp_xmax", 32'(cursor_x), 639);
        chk("clamp_ymin", 32'(cursor_y), 0);
        for (int i = 0; i < 4; i++) begin pkt(8'h28, 8'h00, 8'h80); idle(1); end
        idle(2);
        chk("clamp_ymax", 32'(cursor_y), 479);
        chk("clamp_x_held", 32'(cursor_x), 639);

        // sync error on a header without bit 3
        do_reset();
        se0 = se_cnt;
        strobe(8'h05);
        chk("t3_sync_pulse", 32'(sync_error), 1);
        idle(1);
        chk("t3_sync_clear", 32'(sync_error), 0);
        pkt(8'h08, 8'h01, 8'h00); idle(3);
        chk("t3_x", 32'(cursor_x), 321);
        chk("t3_se_count", 32'(se_cnt - se0), 1);

        // timeout discards partial packet
        do_reset();
        pu0 = pu_cnt;
        strobe(8'h08); strobe(8'h05);
        idle(T + 5);
        pkt(8'h08, 8'h05, 8'h00); idle(3);
        chk("t4_x", 32'(cursor_x), 325);
        chk("t4_y", 32'(cursor_y), 240);
        chk("t4_pu_count", 32'(pu_cnt - pu0), 1);

        // gap of exactly T cycles is still accepted
        pu0 = pu_cnt;
        strobe(8'h08); idle(T - 1); strobe(8'h05); idle(T - 1); strobe(8'h01);
        idle(3);
        chk("t4_edge_x", 32'(cursor_x), 330);
        chk("t4_edge_y", 32'(cursor_y), 239);
        chk("t4_edge_pu", 32'(pu_cnt - pu0), 1);

        // gap of T+1 times out; the late byte is then a bad header
        se0 = se_cnt;
        strobe(8'h08); idle(T); strobe(8'h05); idle(2);
        chk("t4_late_se", 32'(se_cnt - se0), 1);
        chk("t4_late_x", 32'(cursor_x), 330);

        // overflow bits zero the delta but buttons still update
        do_reset();
        pu0 = pu_cnt;
        pkt(8'h48, 8'h7F, 8'h00); idle(3);
        chk("t5_ovf_x", 32'(cursor_x), 320);
        chk("t5_ovf_pu", 32'(pu_cnt - pu0), 1);
        pkt(8'hCF, 8'h7F, 8'h7F); idle(3);
        chk("t5_ovf_xy_y", 32'(cursor_y), 240);
        chk("t5_ovf_buttons", 32'(buttons), 7);

        // reset while waiting for the last byte
        pkt(8'h08, 8'h05, 8'h03); idle(2);
        strobe(8'h08); strobe(8'h05);
        do_reset();
        chk("t5_rst_x", 32'(cursor_x), 320);
        chk("t5_rst_y", 32'(cursor_y), 240);
        chk("t5_rst_buttons", 32'(buttons), 0);
        strobe(8'h03);
        chk("t5_rst_discard", 32'(sync_error), 1);
        idle(2);

        // back-to-back packets, second header lands on the APPLY cycle
        do_reset();
        pu0 = pu_cnt; se0 = se_cnt;
        pkt(8'h08, 8'h05, 8'h03);
        pkt(8'h08, 8'h05, 8'h03);
        idle(3);
        chk("t6_x", 32'(cursor_x), 330);
        chk("t6_y", 32'(cursor_y), 234);
        chk("t6_pu_count", 32'(pu_cnt - pu0), 2);
        chk("t6_no_sync", 32'(se_cnt - se0), 0);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
